// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence-detector path.
// Contents:
//   ser_state_t    - shifter state of par2ser_feeder (idle / shifting)
//   SER_MSB_FIRST  - bit-order selector value: word MSB goes out first
//   SER_LSB_FIRST  - bit-order selector value: word LSB goes out first
package seq_pkg;

  typedef enum logic [0:0] {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  localparam bit SER_MSB_FIRST = 1'b1;
  localparam bit SER_LSB_FIRST = 1'b0;

endpackage

// File: rtl/par2ser_feeder.sv
// Parallel-to-serial converter feeding the serial sequence detector.
// Words arrive over a valid/ready handshake into a hold register and are moved into a shift
// register as soon as it is idle or on its last bit, so consecutive words stream without gaps.
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   din        - parallel word, captured when din_valid && din_ready
//   din_valid  - upstream word valid
//   din_ready  - hold register empty
//   ser_out    - serial bit, IDLE_BIT when ser_valid is low
//   ser_valid  - ser_out carries a payload bit
//   ser_last   - final bit of the current word
//   busy       - a word is held or being shifted
module par2ser_feeder
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = SER_MSB_FIRST,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  if (WIDTH < 2) begin : g_width_check
    $error("par2ser_feeder: WIDTH must be at least 2");
  end

  // Guarded so the declarations below stay legal even when the check above fires.
  localparam int unsigned CntW   = (WIDTH < 2) ? 1 : $clog2(WIDTH);
  localparam int unsigned OutIdx = MSB_FIRST ? WIDTH - 1 : 0;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             hold_full_q, hold_full_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             accept;
  logic             reload;
  logic             on_last;
  logic [WIDTH-1:0] sh_next;

  assign on_last = (state_q == SER_SHIFT) && (cnt_q == CntLast);
  assign accept  = din_valid && !hold_full_q;
  // Idle shifter or last bit going out: the held word takes over with no bubble.
  assign reload  = hold_full_q && ((state_q == SER_IDLE) || (cnt_q == CntLast));
  // Move the next bit into the output position.
  assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SER_IDLE;
      hold_q      <= '0;
      sh_q        <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      sh_q        <= sh_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (reload) begin
      state_d = SER_SHIFT;
    end else if (on_last) begin
      state_d = SER_IDLE;
    end
  end

  // Hold register and shifter datapath
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    // accept and reload never coincide: one needs hold empty, the other hold full.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
    if (reload) begin
      sh_d        = hold_q;
      cnt_d       = '0;
      hold_full_d = 1'b0;
    end else if ((state_q == SER_SHIFT) && (cnt_q != CntLast)) begin
      sh_d  = sh_next;
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Outputs, decoded from registers only
  always_comb begin
    ser_valid = (state_q == SER_SHIFT);
    ser_out   = ser_valid ? sh_q[OutIdx] : IDLE_BIT;
    ser_last  = on_last;
    busy      = ser_valid || hold_full_q;
    din_ready = !hold_full_q;
  end

endmodule
